// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, wait-state
// handling for instruction memory and a saturating bubble counter.
module if_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int unsigned PC_STEP   = 2,
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  write_i,
   input  logic        pcsrc_i,
   input  logic        jump_i,
   input  logic [15:0] branch_target_i,
   input  logic [15:0] jump_target_i,
   output logic [15:0] imem_addr_o,
   input  logic [15:0] imem_rdata_i,
   input  logic        imem_ready_i,
   output logic [15:0] pc_out_o,
   output logic [15:0] ifid_pc_o,
   output logic [15:0] ifid_instr_o,
   output logic        ifid_valid_o,
   output logic [15:0] bubble_cnt_o
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_WAIT = 2'b10
   } state_t;

   localparam logic [15:0] PC_INC = 16'(PC_STEP);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [15:0] pc_r;
   logic [15:0] pc_nxt_s;
   logic [15:0] ifid_pc_r;
   logic [15:0] ifid_pc_nxt_s;
   logic [15:0] ifid_instr_r;
   logic [15:0] ifid_instr_nxt_s;
   logic        ifid_valid_r;
   logic        ifid_valid_nxt_s;
   logic [15:0] bubble_cnt_r;
   logic [15:0] bubble_cnt_nxt_s;
   logic        bubble_count_s;
   logic        redirect_s;

   assign redirect_s = write_i[1] & (pcsrc_i | jump_i);

   // Next-state, next-PC and IF/ID contents, in redirect > stall > fetch priority
   always_comb begin
      state_nxt_s      = state_r;
      pc_nxt_s         = pc_r;
      ifid_pc_nxt_s    = ifid_pc_r;
      ifid_instr_nxt_s = ifid_instr_r;
      ifid_valid_nxt_s = ifid_valid_r;
      bubble_count_s   = 1'b0;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s = ST_RUN;
         end
         ST_RUN, ST_WAIT: begin
            if (redirect_s) begin
               pc_nxt_s         = jump_i ? jump_target_i : branch_target_i;
               ifid_pc_nxt_s    = 16'h0000;
               ifid_instr_nxt_s = NOP_INSTR;
               ifid_valid_nxt_s = 1'b0;
               bubble_count_s   = 1'b1;
               state_nxt_s      = ST_RUN;
            end else if (write_i == 2'b00) begin
               // full stall: defaults already hold PC, IF/ID and state
               state_nxt_s = state_r;
            end else if (write_i == 2'b01) begin
               ifid_pc_nxt_s    = 16'h0000;
               ifid_instr_nxt_s = NOP_INSTR;
               ifid_valid_nxt_s = 1'b0;
               bubble_count_s   = 1'b1;
            end else if (imem_ready_i) begin
               pc_nxt_s    = pc_r + PC_INC;
               state_nxt_s = ST_RUN;
               if (write_i[0]) begin
                  ifid_pc_nxt_s    = pc_r;
                  ifid_instr_nxt_s = imem_rdata_i;
                  ifid_valid_nxt_s = 1'b1;
               end else begin
                  ifid_pc_nxt_s    = 16'h0000;
                  ifid_instr_nxt_s = NOP_INSTR;
                  ifid_valid_nxt_s = 1'b0;
                  bubble_count_s   = 1'b1;
               end
            end else begin
               ifid_pc_nxt_s    = 16'h0000;
               ifid_instr_nxt_s = NOP_INSTR;
               ifid_valid_nxt_s = 1'b0;
               bubble_count_s   = 1'b1;
               state_nxt_s      = ST_WAIT;
            end
         end
         default: begin
            // unreachable encoding: recover through BOOT with a clean bubble
            state_nxt_s      = ST_BOOT;
            pc_nxt_s         = RESET_PC;
            ifid_pc_nxt_s    = 16'h0000;
            ifid_instr_nxt_s = NOP_INSTR;
            ifid_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // Saturating bubble counter increment
   always_comb begin
      if (bubble_count_s && (bubble_cnt_r != 16'hFFFF)) begin
         bubble_cnt_nxt_s = bubble_cnt_r + 16'h0001;
      end else begin
         bubble_cnt_nxt_s = bubble_cnt_r;
      end
   end

   // State, PC, IF/ID and counter registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r      <= ST_BOOT;
         pc_r         <= RESET_PC;
         ifid_pc_r    <= 16'h0000;
         ifid_instr_r <= NOP_INSTR;
         ifid_valid_r <= 1'b0;
         bubble_cnt_r <= 16'h0000;
      end else begin
         state_r      <= state_nxt_s;
         pc_r         <= pc_nxt_s;
         ifid_pc_r    <= ifid_pc_nxt_s;
         ifid_instr_r <= ifid_instr_nxt_s;
         ifid_valid_r <= ifid_valid_nxt_s;
         bubble_cnt_r <= bubble_cnt_nxt_s;
      end
   end

   assign imem_addr_o  = pc_r;
   assign pc_out_o     = pc_r;
   assign ifid_pc_o    = ifid_pc_r;
   assign ifid_instr_o = ifid_instr_r;
   assign ifid_valid_o = ifid_valid_r;
   assign bubble_cnt_o = bubble_cnt_r;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then randomized traffic, all checked
// against a behavioural fetch-stage model.
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic [1:0]  wr;
   logic        pcsrc;
   logic        jump;
   logic [15:0] btgt;
   logic [15:0] jtgt;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        ready;
   logic [15:0] pc_out;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_instr;
   logic        ifid_valid;
   logic [15:0] bubble_cnt;
   logic [15:0] key;

   int tests_run    = 0;
   int tests_failed = 0;

   // model state
   logic [15:0] m_pc;
   logic [15:0] m_ipc;
   logic [15:0] m_instr;
   logic        m_valid;
   logic [15:0] m_cnt;
   bit          m_boot;

   if_stage dut (
      .clk_i          (clk),
      .rst_i          (rst_n),
      .write_i        (wr),
      .pcsrc_i        (pcsrc),
      .jump_i         (jump),
      .branch_target_i(btgt),
      .jump_target_i  (jtgt),
      .imem_addr_o    (imem_addr),
      .imem_rdata_i   (imem_rdata),
      .imem_ready_i   (ready),
      .pc_out_o       (pc_out),
      .ifid_pc_o      (ifid_pc),
      .ifid_instr_o   (ifid_instr),
      .ifid_valid_o   (ifid_valid),
      .bubble_cnt_o   (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction memory: word = key + address
   always_comb imem_rdata = key + imem_addr;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},    pc_out,            m_pc);
      check({tag, ".addr"},  imem_addr,         m_pc);
      check({tag, ".ifpc"},  ifid_pc,           m_ipc);
      check({tag, ".instr"}, ifid_instr,        m_instr);
      check({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, m_valid});
      check({tag, ".cnt"},   bubble_cnt,        m_cnt);
   endtask

   task automatic model_reset();
      m_pc    = 16'h0000;
      m_ipc   = 16'h0000;
      m_instr = 16'h0000;
      m_valid = 1'b0;
      m_cnt   = 16'h0000;
      m_boot  = 1'b1;
   endtask

   task automatic model_bubble();
      m_ipc   = 16'h0000;
      m_instr = 16'h0000;
      m_valid = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
   endtask

   // one rising edge of the fetch stage, expressed as the priority rules
   task automatic model_edge();
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (wr[1] && (pcsrc || jump)) begin
         m_pc = jump ? jtgt : btgt;
         model_bubble();
      end else if (wr == 2'b00) begin
         m_boot = 1'b0;
      end else if (wr == 2'b01) begin
         model_bubble();
      end else if (ready) begin
         if (wr[0]) begin
            m_ipc   = m_pc;
            m_instr = key + m_pc;
            m_valid = 1'b1;
         end else begin
            model_bubble();
         end
         m_pc = m_pc + 16'd2;
      end else begin
         model_bubble();
      end
   endtask

   task automatic drive(input logic [1:0] w, input logic ps, input logic jp,
                        input logic [15:0] b, input logic [15:0] j, input logic rd);
      wr = w; pcsrc = ps; jump = jp; btgt = b; jtgt = j; ready = rd;
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic async_reset_pulse(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      key   = 16'hA000;
      drive(2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");

      rst_n = 1'b1;
      step("boot");
      check("boot_pc_held", pc_out, 16'h0000);

      for (int i = 0; i < 3; i++) step("straight");
      check("straight_pc", pc_out, 16'h0006);
      check("straight_instr", ifid_instr, 16'hA004);

      drive(2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) step("stall");
      drive(2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step("resume");
      check("resume_ifpc", ifid_pc, 16'h0006);
      check("resume_instr", ifid_instr, 16'hA006);
      check("resume_cnt", bubble_cnt, 16'h0000);

      drive(2'b10, 1'b1, 1'b1, 16'h0040, 16'h0080, 1'b1);
      step("redirect_jump_wins");
      check("redirect_pc", pc_out, 16'h0080);
      check("redirect_cnt", bubble_cnt, 16'h0001);

      drive(2'b11, 1'b1, 1'b0, 16'h0010, 16'h0200, 1'b0);
      step("branch");
      drive(2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 2; i++) step("wait");
      check("wait_pc", pc_out, 16'h0010);
      drive(2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step("wait_done");
      check("wait_instr", ifid_instr, 16'hA010);
      check("wait_cnt", bubble_cnt, 16'h0004);

      drive(2'b01, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step("ifid_bubble");
      drive(2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step("pc_only");

      drive(2'b11, 1'b0, 1'b1, 16'h0000, 16'hFFFE, 1'b1);
      step("jump_top");
      drive(2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step("wrap");
      check("wrap_pc", pc_out, 16'h0000);
      drive(2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      step("enter_wait");
      async_reset_pulse("reset_mid_wait");
      drive(2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step("reboot");

      for (int i = 0; i < 600; i++) begin
         key = 16'($urandom);
         drive(2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) == 0),
               16'($urandom) & 16'hFFFE,
               16'($urandom) & 16'hFFFE,
               ($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 99) == 0) begin
            async_reset_pulse("rand_reset");
         end else begin
            step("rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
